// File: rtl/i2c_slave.sv
// I2C target: oversampled and glitch-filtered SCL/SDA, START/STOP detection,
// 7-bit address match and byte transfer to/from user logic via pulse handshakes.
module i2c_slave #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_slave_addr,
  input  logic       i_rx_nack,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_data_needed,
  output logic [7:0] o_rx_data,
  output logic       o_rx_data_valid,
  output logic       o_busy,
  output logic       o_rw,
  output logic       o_start_det,
  output logic       o_stop_det,
  inout  wire        io_sda,
  inout  wire        io_scl
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t        state, state_n;
  logic [1:0]    sync1, sync2, filt, filt_d;
  logic [CW-1:0] stable_cnt [2];
  logic [6:0]    shift, shift_n, tx_shift, tx_shift_n;
  logic [7:0]    rx_data_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic          sda_low, sda_low_n, ack_phase, ack_phase_n;
  logic          busy_n, rw_n, tx_needed_n, rx_valid_n, start_n, stop_n;
  logic          scl_rise, scl_fall, start_cond, stop_cond;

  assign io_sda = sda_low ? 1'b0 : 1'bz;
  assign io_scl = 1'bz;

  // Bit 1 carries SCL, bit 0 SDA. Reset to the idle-high bus level so that
  // leaving reset never manufactures a START or STOP.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1         <= 2'b11;
      sync2         <= 2'b11;
      filt          <= 2'b11;
      filt_d        <= 2'b11;
      stable_cnt[0] <= '0;
      stable_cnt[1] <= '0;
    end else begin
      sync1  <= {io_scl, io_sda};
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          stable_cnt[i] <= '0;
        end else if (stable_cnt[i] == CNT_MAX) begin
          filt[i]       <= sync2[i];
          stable_cnt[i] <= '0;
        end else begin
          stable_cnt[i] <= stable_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign scl_rise   = filt[1] & ~filt_d[1];
  assign scl_fall   = ~filt[1] & filt_d[1];
  assign start_cond = filt[1] & filt_d[0] & ~filt[0];
  assign stop_cond  = filt[1] & ~filt_d[0] & filt[0];

  // START/STOP override any SCL edge seen in the same cycle.
  always_comb begin
    state_n     = state;
    shift_n     = shift;
    tx_shift_n  = tx_shift;
    rx_data_n   = o_rx_data;
    bit_cnt_n   = bit_cnt;
    sda_low_n   = sda_low;
    ack_phase_n = ack_phase;
    busy_n      = o_busy;
    rw_n        = o_rw;
    tx_needed_n = 1'b0;
    rx_valid_n  = 1'b0;
    start_n     = 1'b0;
    stop_n      = 1'b0;
    if (start_cond || stop_cond) begin
      state_n     = start_cond ? ADDR : IDLE;
      bit_cnt_n   = 3'd0;
      sda_low_n   = 1'b0;
      ack_phase_n = 1'b0;
      busy_n      = 1'b0;
      start_n     = start_cond;
      stop_n      = ~start_cond;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          shift_n   = {shift[5:0], filt[0]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (shift == i_slave_addr) begin
              state_n     = ADDR_ACK;
              busy_n      = 1'b1;
              rw_n        = filt[0];
              tx_needed_n = filt[0];
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!ack_phase) begin
            sda_low_n   = 1'b1;
            ack_phase_n = 1'b1;
          end else begin
            ack_phase_n = 1'b0;
            if (o_rw) begin
              state_n    = RD_DATA;
              tx_shift_n = i_tx_data[6:0];
              sda_low_n  = ~i_tx_data[7];
            end else begin
              state_n   = WR_DATA;
              sda_low_n = 1'b0;
            end
          end
        end
        WR_DATA: if (scl_rise) begin
          shift_n   = {shift[5:0], filt[0]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_data_n  = {shift, filt[0]};
            rx_valid_n = 1'b1;
            state_n    = WR_ACK;
          end
        end
        // sda_low remembers whether this byte was ACKed when the ACK clock ends.
        WR_ACK: if (scl_fall) begin
          if (!ack_phase) begin
            sda_low_n   = ~i_rx_nack;
            ack_phase_n = 1'b1;
          end else begin
            ack_phase_n = 1'b0;
            sda_low_n   = 1'b0;
            if (sda_low) begin
              state_n = WR_DATA;
            end else begin
              state_n = WAIT_STOP;
              busy_n  = 1'b0;
            end
          end
        end
        RD_DATA: if (scl_fall) begin
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            sda_low_n = 1'b0;
            state_n   = RD_ACK;
          end else begin
            sda_low_n  = ~tx_shift[6];
            tx_shift_n = {tx_shift[5:0], 1'b0};
          end
        end
        RD_ACK: begin
          if (scl_rise && !ack_phase) begin
            if (!filt[0]) begin
              tx_needed_n = 1'b1;
              ack_phase_n = 1'b1;
            end else begin
              busy_n  = 1'b0;
              state_n = WAIT_STOP;
            end
          end else if (scl_fall && ack_phase) begin
            ack_phase_n = 1'b0;
            tx_shift_n  = i_tx_data[6:0];
            sda_low_n   = ~i_tx_data[7];
            state_n     = RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state            <= IDLE;
      shift            <= '0;
      tx_shift         <= '0;
      bit_cnt          <= '0;
      sda_low          <= 1'b0;
      ack_phase        <= 1'b0;
      o_rx_data        <= '0;
      o_rx_data_valid  <= 1'b0;
      o_tx_data_needed <= 1'b0;
      o_busy           <= 1'b0;
      o_rw             <= 1'b0;
      o_start_det      <= 1'b0;
      o_stop_det       <= 1'b0;
    end else begin
      state            <= state_n;
      shift            <= shift_n;
      tx_shift         <= tx_shift_n;
      bit_cnt          <= bit_cnt_n;
      sda_low          <= sda_low_n;
      ack_phase        <= ack_phase_n;
      o_rx_data        <= rx_data_n;
      o_rx_data_valid  <= rx_valid_n;
      o_tx_data_needed <= tx_needed_n;
      o_busy           <= busy_n;
      o_rw             <= rw_n;
      o_start_det      <= start_n;
      o_stop_det       <= stop_n;
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged bus master with pull-ups drives
// write, read, mismatch, repeated START, glitch and mid-read reset scenarios.
module tb_i2c_slave;

  localparam int FILTER = 4;
  localparam int Q      = 10;

  logic       tb_clk = 1'b0;
  logic       rst;
  logic [6:0] slave_addr;
  logic       rx_nack;
  logic [7:0] tx_data = 8'h00;
  logic       tx_needed, rx_valid, busy, rw, start_det, stop_det;
  logic [7:0] rx_data;
  logic       sda_drv_low = 1'b0;
  logic       scl_drv_low = 1'b0;
  wire        sda_bus, scl_bus;

  assign sda_bus = sda_drv_low ? 1'b0 : 1'bz;
  assign scl_bus = scl_drv_low ? 1'b0 : 1'bz;
  pullup (sda_bus);
  pullup (scl_bus);

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0, tx_cnt = 0, start_cnt = 0, stop_cnt = 0, dut_low_cnt = 0;
  int tx_idx = 0;
  logic [7:0] rx_q [$];
  logic [7:0] tx_table [5] = '{8'hA5, 8'h3C, 8'h96, 8'hC3, 8'h00};

  i2c_slave #(.FILTER_CYCLES(FILTER)) dut (
    .i_clk            (tb_clk),
    .i_rst            (rst),
    .i_slave_addr     (slave_addr),
    .i_rx_nack        (rx_nack),
    .i_tx_data        (tx_data),
    .o_tx_data_needed (tx_needed),
    .o_rx_data        (rx_data),
    .o_rx_data_valid  (rx_valid),
    .o_busy           (busy),
    .o_rw             (rw),
    .o_start_det      (start_det),
    .o_stop_det       (stop_det),
    .io_sda           (sda_bus),
    .io_scl           (scl_bus)
  );

  always #5 tb_clk = ~tb_clk;

  // User-side model: count pulses, log received bytes, serve read bytes in order.
  always @(negedge tb_clk) begin
    if (!rst) begin
      if (rx_valid) begin
        rx_cnt++;
        rx_q.push_back(rx_data);
      end
      if (tx_needed) begin
        tx_cnt++;
        tx_data = tx_table[tx_idx];
        if (tx_idx < 4) tx_idx++;
      end
      if (start_det) start_cnt++;
      if (stop_det) stop_cnt++;
      if (sda_bus === 1'b0 && !sda_drv_low) dut_low_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge tb_clk);
    #1;
  endtask

  // One SCL clock; the SCL high phase optionally carries a FILTER-1 cycle low glitch.
  task automatic applyStimulus(input logic bit_out, input logic glitch, output logic bit_in);
    sda_drv_low = ~bit_out;
    wait_clk(Q);
    scl_drv_low = 1'b0;
    if (glitch) begin
      wait_clk(4);
      scl_drv_low = 1'b1;
      wait_clk(FILTER - 1);
      scl_drv_low = 1'b0;
      wait_clk(Q - 4 - (FILTER - 1));
    end else begin
      wait_clk(Q);
    end
    bit_in = sda_bus;
    wait_clk(Q);
    scl_drv_low = 1'b1;
    wait_clk(Q);
  endtask

  task automatic bus_start;
    sda_drv_low = 1'b0; wait_clk(Q);
    scl_drv_low = 1'b0; wait_clk(Q);
    sda_drv_low = 1'b1; wait_clk(Q);
    scl_drv_low = 1'b1; wait_clk(Q);
  endtask

  task automatic bus_stop;
    sda_drv_low = 1'b1; wait_clk(Q);
    scl_drv_low = 1'b0; wait_clk(Q);
    sda_drv_low = 1'b0; wait_clk(2 * Q);
  endtask

  task automatic write_byte(input logic [7:0] data, input logic glitch_bit3, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) applyStimulus(data[i], glitch_bit3 && (i == 3), r);
    applyStimulus(1'b1, 1'b0, r);
    acked = ~r;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] data);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b1, 1'b0, r);
      data[i] = r;
    end
    applyStimulus(~ack, 1'b0, r);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    logic       r;
    int         base_rx, base_tx, base_start, base_stop, base_low, qb;

    rst = 1'b1;
    slave_addr = 7'h55;
    rx_nack = 1'b0;
    wait_clk(3);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rw", rw, 0);
    checkOutput("rst_rx_data", rx_data, 0);
    checkOutput("rst_sda", sda_bus, 1);
    checkOutput("rst_pulses", {tx_needed, rx_valid, start_det, stop_det}, 0);
    rst = 1'b0;
    wait_clk(5);

    // Write two bytes to 0x55.
    base_rx = rx_cnt; base_stop = stop_cnt; qb = rx_q.size();
    bus_start();
    write_byte(8'hAA, 1'b0, ack);
    checkOutput("t1_addr_ack", ack, 1);
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_rw", rw, 0);
    write_byte(8'h02, 1'b0, ack);
    checkOutput("t1_ack0", ack, 1);
    write_byte(8'h57, 1'b0, ack);
    checkOutput("t1_ack1", ack, 1);
    bus_stop();
    checkOutput("t1_rx_cnt", rx_cnt - base_rx, 2);
    checkOutput("t1_rx0", rx_q[qb], 8'h02);
    checkOutput("t1_rx1", rx_q[qb + 1], 8'h57);
    checkOutput("t1_rx_data", rx_data, 8'h57);
    checkOutput("t1_stop", stop_cnt - base_stop, 1);
    checkOutput("t1_busy_end", busy, 0);

    // Read two bytes, ACK then NACK.
    base_tx = tx_cnt;
    bus_start();
    write_byte(8'hAB, 1'b0, ack);
    checkOutput("t2_addr_ack", ack, 1);
    checkOutput("t2_rw", rw, 1);
    read_byte(1'b1, rd);
    checkOutput("t2_byte0", rd, 8'hA5);
    read_byte(1'b0, rd);
    checkOutput("t2_byte1", rd, 8'h3C);
    checkOutput("t2_tx_cnt", tx_cnt - base_tx, 2);
    checkOutput("t2_busy_nack", busy, 0);
    checkOutput("t2_sda_released", sda_bus, 1);
    bus_stop();

    // Address mismatch: target stays silent.
    base_rx = rx_cnt; base_tx = tx_cnt; base_low = dut_low_cnt;
    bus_start();
    write_byte(8'hA8, 1'b0, ack);
    checkOutput("t3_addr_nack", ack, 0);
    write_byte(8'h55, 1'b0, ack);
    checkOutput("t3_data_nack", ack, 0);
    checkOutput("t3_busy", busy, 0);
    checkOutput("t3_no_drive", dut_low_cnt - base_low, 0);
    checkOutput("t3_no_pulses", (rx_cnt - base_rx) + (tx_cnt - base_tx), 0);
    bus_stop();

    // Write, repeated START, read.
    base_start = start_cnt;
    bus_start();
    write_byte(8'hAA, 1'b0, ack);
    checkOutput("t4_rw_write", rw, 0);
    write_byte(8'h11, 1'b0, ack);
    checkOutput("t4_ack", ack, 1);
    bus_start();
    write_byte(8'hAB, 1'b0, ack);
    checkOutput("t4_rw_read", rw, 1);
    read_byte(1'b0, rd);
    checkOutput("t4_read", rd, 8'h96);
    checkOutput("t4_rx_data", rx_data, 8'h11);
    checkOutput("t4_starts", start_cnt - base_start, 2);
    bus_stop();

    // SCL glitch mid-byte, then a NACKed but still delivered byte.
    base_rx = rx_cnt;
    bus_start();
    write_byte(8'hAA, 1'b0, ack);
    write_byte(8'h3C, 1'b1, ack);
    checkOutput("t5_glitch_ack", ack, 1);
    checkOutput("t5_glitch_data", rx_data, 8'h3C);
    rx_nack = 1'b1;
    write_byte(8'hC7, 1'b0, ack);
    rx_nack = 1'b0;
    checkOutput("t5_nack", ack, 0);
    checkOutput("t5_nack_data", rx_data, 8'hC7);
    checkOutput("t5_rx_cnt", rx_cnt - base_rx, 2);
    bus_stop();

    // Reset while the target holds SDA low during a read (byte 0xC3, bit 5 = 0).
    bus_start();
    write_byte(8'hAB, 1'b0, ack);
    applyStimulus(1'b1, 1'b0, r);
    checkOutput("t6_bit7", r, 1);
    applyStimulus(1'b1, 1'b0, r);
    checkOutput("t6_bit6", r, 1);
    checkOutput("t6_sda_driven", sda_bus, 0);
    rst = 1'b1;
    #2;
    checkOutput("t6_sda_async", sda_bus, 1);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_rw", rw, 0);
    checkOutput("t6_rx_data", rx_data, 0);
    wait_clk(2);
    rst = 1'b0;
    wait_clk(5);
    bus_start();
    write_byte(8'hAA, 1'b0, ack);
    checkOutput("t6_post_ack", ack, 1);
    write_byte(8'h66, 1'b0, ack);
    checkOutput("t6_post_data", rx_data, 8'h66);
    bus_stop();
    checkOutput("t6_post_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
